game_status_gen: RTL and testbench

// Produces the status inputs consumed by the screen/phase controller:

---
 rtl/game_status_gen_if.sv | 29 ++
 rtl/game_status_gen.sv | 156 +++++++++++++++
 tb/tb_game_status_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_status_gen_if.sv
// Status bus between the game status generator and its environment.
// Latency: n/a (wires only). Backpressure: none; all inputs are levels or 1-cycle pulses.
// Ports: frame_clk/keycode/phase/hit/fall/flag_reached in; status levels out.
interface game_status_gen_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [3:0] phase;
  logic       hit;
  logic       fall;
  logic       flag_reached;
  logic       playernum_select;
  logic [1:0] player_count;
  logic       mario_alive;
  logic       game_end;
  logic [1:0] lives;
  logic [9:0] time_left;

  // Environment side: drives stimulus, observes status.
  modport master (
    output frame_clk, keycode, phase, hit, fall, flag_reached,
    input  playernum_select, player_count, mario_alive, game_end, lives, time_left
  );

  // Generator side.
  modport slave (
    input  frame_clk, keycode, phase, hit, fall, flag_reached,
    output playernum_select, player_count, mario_alive, game_end, lives, time_left
  );
endinterface

// File: rtl/game_status_gen.sv
// Game status generator: player select, lives, level timer, invulnerability, end flags.
// Latency: status updates 1 cycle after an input pulse; frame ticks act 2 cycles after frame_clk rises.
// Backpressure: none; counting freezes whenever phase is not GAME.
// Ports: Clk, RESET_N (sync, active low); bus = game_status_gen_if.slave.
module game_status_gen #(
  parameter int         LIVES_INIT      = 3,
  parameter int         TIME_INIT       = 400,
  parameter int         FRAMES_PER_TICK = 24,
  parameter int         INVULN_FRAMES   = 60,
  parameter logic [7:0] KEY_ONE         = 8'h1E,
  parameter logic [7:0] KEY_TWO         = 8'h1F
) (
  input  logic               Clk,
  input  logic               RESET_N,
  game_status_gen_if.slave   bus
);

  localparam int CW = $clog2(FRAMES_PER_TICK + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] PH_STARTER = 4'b1000;
  localparam logic [3:0] PH_GAME    = 4'b0100;

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic [1:0]    pc_q, pc_d;
  logic          alive_q, alive_d;
  logic          gend_q, gend_d;
  logic [1:0]    lives_q, lives_d;
  logic [9:0]    time_q, time_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] inv_q, inv_d;
  logic          fclk_q;
  logic          tick_q, tick_d;

  logic          timer_dec;
  logic [9:0]    time_nxt;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pc_d      = pc_q;
    alive_d   = alive_q;
    gend_d    = gend_q;
    lives_d   = lives_q;
    time_d    = time_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    timer_dec = 1'b0;
    time_nxt  = time_q;
    // Registered rising-edge detect; the tick acts one cycle after it is seen.
    tick_d    = bus.frame_clk & ~fclk_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.phase == PH_STARTER) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (bus.keycode == KEY_ONE) begin
          pc_d    = 2'd1;
          sel_d   = 1'b1;
          state_d = ST_PLAY;
        end else if (bus.keycode == KEY_TWO) begin
          pc_d    = 2'd2;
          sel_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.phase == PH_GAME) begin
          if (tick_q) begin
            if (inv_q != '0) inv_d = inv_q - IW'(1);
            if (cnt_q == CW'(FRAMES_PER_TICK - 1)) begin
              cnt_d     = '0;
              timer_dec = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          if (timer_dec && time_q != 10'd0) time_nxt = time_q - 10'd1;

          // Priority: flag > fall > timer expiry > hit.
          if (bus.flag_reached) begin
            gend_d  = 1'b1;
            state_d = ST_DONE;
          end else if (bus.fall) begin
            lives_d = 2'd0;
            alive_d = 1'b0;
            state_d = ST_DONE;
          end else if (timer_dec && time_nxt == 10'd0) begin
            time_d  = 10'd0;
            alive_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            time_d = time_nxt;
            // Any hit during immunity is ignored, including on the last life.
            if (bus.hit && inv_q == '0) begin
              if (lives_q > 2'd1) begin
                lives_d = lives_q - 2'd1;
                inv_d   = IW'(INVULN_FRAMES);
              end else begin
                lives_d = 2'd0;
                alive_d = 1'b0;
                state_d = ST_DONE;
              end
            end
          end
        end
      end
      default: begin
        // ST_DONE: everything frozen until reset.
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      pc_q    <= 2'd0;
      alive_q <= 1'b1;
      gend_q  <= 1'b0;
      lives_q <= 2'(LIVES_INIT);
      time_q  <= 10'(TIME_INIT);
      cnt_q   <= '0;
      inv_q   <= '0;
      fclk_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pc_q    <= pc_d;
      alive_q <= alive_d;
      gend_q  <= gend_d;
      lives_q <= lives_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      fclk_q  <= bus.frame_clk;
      tick_q  <= tick_d;
    end
  end

  assign bus.playernum_select = sel_q;
  assign bus.player_count     = pc_q;
  assign bus.mario_alive      = alive_q;
  assign bus.game_end         = gend_q;
  assign bus.lives            = lives_q;
  assign bus.time_left        = time_q;

endmodule

// File: tb/tb_game_status_gen.sv
// Bench for game_status_gen: table vectors plus hand sequences, scoreboard queue.
// Latency: every check samples 1 time unit after the clock edge it follows.
// Backpressure: none.
module tb_game_status_gen;

  localparam int FPT_A = 2;
  localparam int INV_A = 60;

  typedef struct packed {
    logic       sel;
    logic [1:0] pc;
    logic       alive;
    logic       gend;
    logic [1:0] lives;
    logic [9:0] tl;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic       fclk;
    logic [7:0] key;
    logic [3:0] ph;
    outs_t      exp;
    string      nm;
  } vec_t;

  logic Clk = 1'b0;
  logic rst_a, rst_b;
  always #5 Clk = ~Clk;

  game_status_gen_if ifa ();
  game_status_gen_if ifb ();

  game_status_gen #(.FRAMES_PER_TICK(FPT_A), .INVULN_FRAMES(INV_A)) dut_a (
    .Clk(Clk), .RESET_N(rst_a), .bus(ifa));
  game_status_gen #(.TIME_INIT(2), .FRAMES_PER_TICK(1)) dut_b (
    .Clk(Clk), .RESET_N(rst_b), .bus(ifb));

  int checks = 0;
  int errors = 0;
  outs_t exp_q[$];

  // Model state for dut_a.
  outs_t m;
  int    m_cnt, m_inv;
  bit    m_done, m_game;

  vec_t tv[19];

  function automatic outs_t mko(bit s, logic [1:0] pc, bit al, bit ge, logic [1:0] lv, logic [9:0] tl);
    outs_t o;
    o.sel = s; o.pc = pc; o.alive = al; o.gend = ge; o.lives = lv; o.tl = tl;
    return o;
  endfunction

  function automatic outs_t outs_a();
    return mko(ifa.playernum_select, ifa.player_count, ifa.mario_alive, ifa.game_end, ifa.lives, ifa.time_left);
  endfunction

  function automatic outs_t outs_b();
    return mko(ifb.playernum_select, ifb.player_count, ifb.mario_alive, ifb.game_end, ifb.lives, ifb.time_left);
  endfunction

  task automatic check_pop(input string nm, input outs_t act);
    outs_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      if (act !== e)
        begin
          errors++;
          $display("FAIL %s: got sel=%0d pc=%0d alive=%0d end=%0d lives=%0d time=%0d, want sel=%0d pc=%0d alive=%0d end=%0d lives=%0d time=%0d",
                   nm, act.sel, act.pc, act.alive, act.gend, act.lives, act.tl,
                   e.sel, e.pc, e.alive, e.gend, e.lives, e.tl);
        end
    end
  endtask

  task automatic cyc_a(input string nm);
    exp_q.push_back(m);
    @(posedge Clk); #1;
    check_pop(nm, outs_a());
  endtask

  task automatic cyc_b(input string nm, input outs_t e);
    exp_q.push_back(e);
    @(posedge Clk); #1;
    check_pop(nm, outs_b());
  endtask

  task automatic mdl_reset();
    m = mko(0, 0, 1, 0, 3, 400);
    m_cnt = 0; m_inv = 0; m_done = 0; m_game = 0;
  endtask

  task automatic mdl_tick();
    if (!m_done && m_game) begin
      if (m_inv > 0) m_inv--;
      m_cnt++;
      if (m_cnt == FPT_A) begin
        m_cnt = 0;
        if (m.tl != 10'd0) m.tl = m.tl - 10'd1;
        if (m.tl == 10'd0) begin m.alive = 0; m_done = 1; end
      end
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b0; ifa.phase = 4'b0000; ifa.keycode = 8'h00;
    mdl_reset();
    cyc_a("reset_a");
    rst_a = 1'b1;
  endtask

  task automatic select_a(input logic [7:0] key);
    ifa.phase = 4'b1000; ifa.keycode = 8'h00;
    cyc_a("sel_idle");
    ifa.keycode = key;
    m.sel = 1; m.pc = (key == 8'h1E) ? 2'd1 : 2'd2;
    cyc_a("sel_key");
    ifa.keycode = 8'h00;
    ifa.phase = 4'b0100; m_game = 1;
    cyc_a("enter_game");
  endtask

  task automatic edges_a(input int n);
    for (int k = 0; k < n; k++) begin
      ifa.frame_clk = 1'b1;
      cyc_a("edge_hi");
      ifa.frame_clk = 1'b0;
      mdl_tick();
      cyc_a("edge_lo");
    end
  endtask

  task automatic hit_a(input string nm);
    ifa.hit = 1'b1;
    if (!m_done && m_game && m_inv == 0) begin
      if (m.lives > 2'd1) begin m.lives = m.lives - 2'd1; m_inv = INV_A; end
      else begin m.lives = 0; m.alive = 0; m_done = 1; end
    end
    cyc_a(nm);
    ifa.hit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t r, s2;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.frame_clk = 0; ifa.keycode = 0; ifa.phase = 0; ifa.hit = 0; ifa.fall = 0; ifa.flag_reached = 0;
    ifb.frame_clk = 0; ifb.keycode = 0; ifb.phase = 0; ifb.hit = 0; ifb.fall = 0; ifb.flag_reached = 0;

    r  = mko(0, 0, 1, 0, 3, 400);
    s2 = mko(1, 2, 1, 0, 3, 400);
    tv[0]  = '{1'b0, 1'b0, 8'h00, 4'b0000, r, "reset"};
    tv[1]  = '{1'b1, 1'b0, 8'h00, 4'b0000, r, "idle_hold"};
    tv[2]  = '{1'b1, 1'b0, 8'h00, 4'b1000, r, "to_select"};
    tv[3]  = '{1'b1, 1'b0, 8'h1F, 4'b1000, s2, "key_two"};
    tv[4]  = '{1'b1, 1'b0, 8'h00, 4'b1000, s2, "key_release"};
    tv[5]  = '{1'b1, 1'b0, 8'h1E, 4'b1000, s2, "key_one_ignored"};
    tv[6]  = '{1'b1, 1'b0, 8'h00, 4'b0100, s2, "enter_game"};
    tv[7]  = '{1'b1, 1'b1, 8'h00, 4'b0100, s2, "e1_hi"};
    tv[8]  = '{1'b1, 1'b0, 8'h00, 4'b0100, s2, "e1_lo"};
    tv[9]  = '{1'b1, 1'b1, 8'h00, 4'b0100, s2, "e2_hi"};
    tv[10] = '{1'b1, 1'b0, 8'h00, 4'b0100, mko(1, 2, 1, 0, 3, 399), "e2_lo"};
    tv[11] = '{1'b1, 1'b1, 8'h00, 4'b0100, mko(1, 2, 1, 0, 3, 399), "e3_hi"};
    tv[12] = '{1'b1, 1'b0, 8'h00, 4'b0100, mko(1, 2, 1, 0, 3, 399), "e3_lo"};
    tv[13] = '{1'b1, 1'b1, 8'h00, 4'b0100, mko(1, 2, 1, 0, 3, 399), "e4_hi"};
    tv[14] = '{1'b1, 1'b0, 8'h00, 4'b0100, mko(1, 2, 1, 0, 3, 398), "e4_lo"};
    tv[15] = '{1'b1, 1'b1, 8'h00, 4'b0010, mko(1, 2, 1, 0, 3, 398), "dead_hi1"};
    tv[16] = '{1'b1, 1'b0, 8'h00, 4'b0010, mko(1, 2, 1, 0, 3, 398), "dead_lo1"};
    tv[17] = '{1'b1, 1'b1, 8'h00, 4'b0010, mko(1, 2, 1, 0, 3, 398), "dead_hi2"};
    tv[18] = '{1'b1, 1'b0, 8'h00, 4'b0010, mko(1, 2, 1, 0, 3, 398), "dead_lo2"};

    for (int i = 0; i < 19; i++) begin
      rst_a = tv[i].rst_n; ifa.frame_clk = tv[i].fclk;
      ifa.keycode = tv[i].key; ifa.phase = tv[i].ph;
      exp_q.push_back(tv[i].exp);
      @(posedge Clk); #1;
      check_pop(tv[i].nm, outs_a());
    end

    // Lives and invulnerability, continuing from the table state.
    m = mko(1, 2, 1, 0, 3, 398); m_cnt = 0; m_inv = 0; m_done = 0; m_game = 0;
    ifa.phase = 4'b0100; m_game = 1;
    cyc_a("regame");
    hit_a("hit_3to2");
    edges_a(5);
    hit_a("hit_immune");
    edges_a(60);
    hit_a("hit_2to1");
    edges_a(65);
    hit_a("hit_1to0");
    ifa.fall = 1'b1; cyc_a("fall_after_dead"); ifa.fall = 1'b0;
    edges_a(2);

    // Reset in the middle of play with one life left.
    reset_a();
    select_a(8'h1F);
    hit_a("r_hit1");
    edges_a(65);
    hit_a("r_hit2");
    edges_a(3);
    rst_a = 1'b0;
    mdl_reset();
    cyc_a("mid_reset");
    rst_a = 1'b1;
    cyc_a("after_reset");

    // Flag and hit together on the last life: flag wins.
    select_a(8'h1E);
    hit_a("f_hit1");
    edges_a(65);
    hit_a("f_hit2");
    ifa.flag_reached = 1'b1; ifa.hit = 1'b1;
    m.gend = 1; m_done = 1;
    cyc_a("flag_and_hit");
    ifa.flag_reached = 1'b0; ifa.hit = 1'b0;
    ifa.fall = 1'b1; cyc_a("fall_after_flag"); ifa.fall = 1'b0;
    edges_a(3);

    // Fall ends the game regardless of lives.
    reset_a();
    select_a(8'h1F);
    ifa.fall = 1'b1;
    m.lives = 0; m.alive = 0; m_done = 1;
    cyc_a("fall");
    ifa.fall = 1'b0;
    hit_a("hit_after_fall");

    // Timer expiry on the short-timer instance.
    rst_b = 1'b0;
    cyc_b("b_reset", mko(0, 0, 1, 0, 3, 2));
    rst_b = 1'b1; ifb.phase = 4'b1000;
    cyc_b("b_select", mko(0, 0, 1, 0, 3, 2));
    ifb.keycode = 8'h1E;
    cyc_b("b_key_one", mko(1, 1, 1, 0, 3, 2));
    ifb.keycode = 8'h00; ifb.phase = 4'b0100;
    cyc_b("b_game", mko(1, 1, 1, 0, 3, 2));
    ifb.frame_clk = 1'b1; cyc_b("b_e1_hi", mko(1, 1, 1, 0, 3, 2));
    ifb.frame_clk = 1'b0; cyc_b("b_e1_lo", mko(1, 1, 1, 0, 3, 1));
    ifb.frame_clk = 1'b1; cyc_b("b_e2_hi", mko(1, 1, 1, 0, 3, 1));
    ifb.frame_clk = 1'b0; cyc_b("b_e2_lo", mko(1, 1, 0, 0, 3, 0));
    for (int k = 0; k < 3; k++) begin
      ifb.frame_clk = 1'b1; cyc_b("b_extra_hi", mko(1, 1, 0, 0, 3, 0));
      ifb.frame_clk = 1'b0; cyc_b("b_extra_lo", mko(1, 1, 0, 0, 3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
